bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per cycle, then correct each BCD digit.
- Sits on the input side of the fibonacci datapath. It converts the decimal index entered on the switches as packed BCD (e.g. sw = 8'h25 means 25) into the binary operand for the fibonacci core.
- It is the inverse of the binary-to-BCD converter on the display side.

---
 rtl/bcd2bin_seq.sv | 117 +++++++++++
 tb/tb_bcd2bin_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per cycle).
// Optional operand digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd2bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  ready,
  output logic                  done_tick,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [SR_W-1:0]   sr_next;
  logic [CNT_W-1:0]  n;

  // One iteration: shift right, then pull every BCD digit >= 8 down by 3.
  // The binary result accumulates in the low BIN_W bits, below the digits.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    sr_shift = sr >> 1;
    sr_next  = sr_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_shift[BIN_W + 4*d +: 4] >= 4'd8)
        sr_next[BIN_W + 4*d +: 4] = sr_shift[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic chk_fail;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (v[4*d +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      bin       <= '0;
      sr        <= '0;
      n         <= '0;
`ifdef BCD2BIN_CHECK_EN
      err       <= 1'b0;
      chk_fail  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_tick <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            sr    <= {bcd, {BIN_W{1'b0}}};
            n     <= CNT_W'(BIN_W - 1);
            state <= OP;
`ifdef BCD2BIN_CHECK_EN
            // A bad operand skips the iterations and finishes on the next edge.
            chk_fail <= has_bad_digit(bcd);
            if (has_bad_digit(bcd)) n <= '0;
`endif
          end
        end

        OP: begin
          sr <= sr_next;
          if (n == '0) begin
            state     <= DONE;
            done_tick <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
            bin <= chk_fail ? '0 : sr_next[BIN_W-1:0];
            err <= chk_fail;
`else
            bin <= sr_next[BIN_W-1:0];
`endif
          end else begin
            n <= n - 1'b1;
          end
        end

        DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: decimal-value model plus directed vectors,
// on a 2-digit/7-bit instance and a 3-digit/10-bit instance.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  bcd0;
  logic [11:0] bcd1;
  logic        ready0, done0, err0;
  logic        ready1, done1, err1;
  logic [6:0]  bin0;
  logic [9:0]  bin1;

  always #5 clk = ~clk;

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bcd(bcd0),
    .ready(ready0), .done_tick(done0), .bin(bin0), .err(err0)
  );

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bcd(bcd1),
    .ready(ready1), .done_tick(done1), .bin(bin1), .err(err1)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a conversion is the decimal value of the digits, visible after a fixed delay.
  bit m_valid = 1'b0;
  bit m_ready[2];
  bit m_done[2];
  bit m_err[2];
  bit p_err[2];
  int m_bin[2];
  int p_bin[2];
  int m_cnt[2];

  task automatic model_step(input int id, input bit r, input bit st,
                            input logic [11:0] b, input int nd, input int bw);
    int  val;
    bit  bad;
    if (r) begin
      m_ready[id] = 1'b1; m_done[id] = 1'b0; m_bin[id] = 0;
      m_err[id] = 1'b0;   m_cnt[id] = 0;
    end else if (m_done[id]) begin
      m_done[id]  = 1'b0;
      m_ready[id] = 1'b1;
    end else if (m_cnt[id] > 0) begin
      m_cnt[id]--;
      if (m_cnt[id] == 0) begin
        m_done[id] = 1'b1;
        m_bin[id]  = p_bin[id];
        m_err[id]  = p_err[id];
      end
    end else if (m_ready[id] && st) begin
      val = 0;
      bad = 1'b0;
      for (int i = nd - 1; i >= 0; i--) begin
        val = val * 10 + int'(b[4*i +: 4]);
        if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      m_ready[id] = 1'b0;
      p_bin[id]   = val;
      p_err[id]   = 1'b0;
      m_cnt[id]   = bw;
`ifdef BCD2BIN_CHECK_EN
      if (bad) begin
        p_bin[id] = 0;
        p_err[id] = 1'b1;
        m_cnt[id] = 1;
      end
`endif
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_valid = 1'b1;
    model_step(0, rst, start0, {4'h0, bcd0}, 2, 7);
    model_step(1, rst, start1, bcd1, 3, 10);
  end

  always @(negedge clk) begin
    if (done0) done_count++;
    if (m_valid) begin
      check("ready0", int'(ready0), int'(m_ready[0]));
      check("done0",  int'(done0),  int'(m_done[0]));
      check("bin0",   int'(bin0),   m_bin[0]);
      check("err0",   int'(err0),   int'(m_err[0]));
      check("ready1", int'(ready1), int'(m_ready[1]));
      check("done1",  int'(done1),  int'(m_done[1]));
      check("bin1",   int'(bin1),   m_bin[1]);
      check("err1",   int'(err1),   int'(m_err[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [7:0] b, input int eb, input int ee,
                      input int lat, input string tag);
    int ks;
    bit got;
    start0 = 1'b1; bcd0 = b;
    tick();
    start0 = 1'b0;
    ks  = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (done0) got = 1'b1;
    end
    check({tag, "_seen"}, int'(got), 1);
    check({tag, "_lat"},  cyc - ks, lat);
    check({tag, "_bin"},  int'(bin0), eb);
    check({tag, "_err"},  int'(err0), ee);
    tick();
    check({tag, "_ready"}, int'(ready0), 1);
  endtask

  task automatic run1(input logic [11:0] b, input int eb, input string tag);
    int ks;
    bit got;
    start1 = 1'b1; bcd1 = b;
    tick();
    start1 = 1'b0;
    ks  = cyc;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (done1) got = 1'b1;
    end
    check({tag, "_seen"}, int'(got), 1);
    check({tag, "_lat"},  cyc - ks, 10);
    check({tag, "_bin"},  int'(bin1), eb);
    tick();
    check({tag, "_ready"}, int'(ready1), 1);
  endtask

  initial begin
    int d0;
    bit rdy;
    rst = 1'b1; start0 = 1'b0; bcd0 = '0; start1 = 1'b0; bcd1 = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_ready", int'(ready0), 1);
    check("rst_done",  int'(done0),  0);
    check("rst_bin",   int'(bin0),   0);
    check("rst_err",   int'(err0),   0);

    run0(8'h15, 15, 0, 7, "c15");
    run0(8'h00, 0,  0, 7, "c00");
    run0(8'h09, 9,  0, 7, "c09");
    run0(8'h10, 10, 0, 7, "c10");
    run0(8'h99, 99, 0, 7, "c99");
    run0(8'h25, 25, 0, 7, "c25");

    // start held high; bcd scrambled whenever a conversion is in flight
    bcd0 = 8'h21; start0 = 1'b1;
    d0 = done_count;
    for (int i = 0; i < 40; i++) begin
      tick();
      bcd0 = m_ready[0] ? 8'h21 : 8'h47;
    end
    start0 = 1'b0; bcd0 = 8'h21;
    check("held_dones", done_count - d0, 4);
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      tick();
      if (ready0) rdy = 1'b1;
    end
    check("held_drain", int'(rdy), 1);
    check("held_bin", int'(bin0), 21);

    // reset three cycles into a conversion
    start0 = 1'b1; bcd0 = 8'h20;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_done",  int'(done0),  0);
    check("abort_bin",   int'(bin0),   0);
    check("abort_ready", int'(ready0), 1);
    run0(8'h20, 20, 0, 7, "c20");

`ifdef BCD2BIN_CHECK_EN
    run0(8'h1A, 0,  1, 1, "bad1a");
    run0(8'h33, 33, 0, 7, "c33");
`endif

    run1(12'h999, 999, "w999");
    run1(12'h512, 512, "w512");
    run1(12'h000, 0,   "w000");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
